// File: rtl/seq_detector.sv
// Purpose : serial pattern detector; pulses out for one cycle when the last W bits equal PATTERN (overlapping matches allowed).
// Latency : out is registered and rises right after the edge that samples the final pattern bit.
// Backpressure: none; one input bit is consumed on every rising clk edge.
//
// Ports:
//   clk         - system clock, rising-edge sampling
//   reset       - asynchronous active-low reset
//   in          - serial data bit
//   out         - one-cycle match pulse (registered)
//   match_count - saturating 8-bit match counter (only when SEQ_GEN_COUNT_EN is defined)
//
// Build option: define SEQ_GEN_COUNT_EN to add the match_count output and its counter.
module seq_detector #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = 4'b1101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
`ifdef SEQ_GEN_COUNT_EN
    output logic [7:0] match_count,
`endif
    output logic       out
);

    localparam int            CW        = $clog2(W + 1);
    localparam logic [CW-1:0] FILL_MAX  = CW'(W);
    localparam logic [CW-1:0] FILL_LAST = CW'(W - 1);

    logic [W-1:0]  hist;
    logic [W-1:0]  hist_nxt;
    logic [CW-1:0] fill;
    logic          full_nxt;
    logic          hit;

    // Newest bit enters the LSB, so hist[W-1] is the oldest bit, matching
    // PATTERN's MSB-first ordering.
    assign hist_nxt = (hist << 1) | W'(in);

    // The window is complete once the bit being sampled now is the W-th since
    // reset; this keeps the zero-filled register from faking a match.
    assign full_nxt = (fill >= FILL_LAST);
    assign hit      = full_nxt && (hist_nxt == PATTERN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
            out  <= 1'b0;
        end else begin
            hist <= hist_nxt;
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
            out  <= hit;
        end
    end

`ifdef SEQ_GEN_COUNT_EN
    // Counts on the same edge that raises out; holds at 255 instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_count <= 8'd0;
        end else if (hit && (match_count != 8'hFF)) begin
            match_count <= match_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Purpose : directed bench for seq_detector with three instances (PATTERN 1101, 1111, 0001).
// Latency : outputs are sampled 1 time unit after each rising clk edge.
// Backpressure: none; stimulus drives one bit per cycle.
module tb_seq_detector;

    logic clk = 1'b0;
    logic rst_n [3];
    logic din   [3];
    logic dout  [3];
`ifdef SEQ_GEN_COUNT_EN
    logic [7:0] cnt [3];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector #(.W(4), .PATTERN(4'b1101)) u_p1101 (
        .clk(clk), .reset(rst_n[0]), .in(din[0]),
`ifdef SEQ_GEN_COUNT_EN
        .match_count(cnt[0]),
`endif
        .out(dout[0])
    );

    seq_detector #(.W(4), .PATTERN(4'b1111)) u_p1111 (
        .clk(clk), .reset(rst_n[1]), .in(din[1]),
`ifdef SEQ_GEN_COUNT_EN
        .match_count(cnt[1]),
`endif
        .out(dout[1])
    );

    seq_detector #(.W(4), .PATTERN(4'b0001)) u_p0001 (
        .clk(clk), .reset(rst_n[2]), .in(din[2]),
`ifdef SEQ_GEN_COUNT_EN
        .match_count(cnt[2]),
`endif
        .out(dout[2])
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

`ifdef SEQ_GEN_COUNT_EN
    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
`endif

    // Drive one bit into instance d, let it be sampled, then check out.
    task automatic drive(input int d, input logic b, input logic exp, input string tag);
        din[d] = b;
        @(posedge clk);
        #1;
        chk(tag, dout[d], exp);
    endtask

    // Mid-cycle asynchronous reset pulse on instance d; out must clear at once.
    task automatic pulse_reset(input int d, input string tag);
        #3;
        rst_n[d] = 1'b0;
        #1;
        chk(tag, dout[d], 1'b0);
`ifdef SEQ_GEN_COUNT_EN
        chk8({tag, "_cnt"}, cnt[d], 8'd0);
`endif
        #1;
        rst_n[d] = 1'b1;
    endtask

    logic [11:0] ref_bits;
    logic [11:0] ref_exp;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b1;
            din[i]   = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;

        // Reset held for two edges with toggling input.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++) din[i] = (c == 0);
            @(posedge clk);
        end
        #1;
        chk("reset_out_p1101", dout[0], 1'b0);
        chk("reset_out_p1111", dout[1], 1'b0);
        chk("reset_out_p0001", dout[2], 1'b0);
`ifdef SEQ_GEN_COUNT_EN
        chk8("reset_cnt_p1101", cnt[0], 8'd0);
        chk8("reset_cnt_p1111", cnt[1], 8'd0);
`endif
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // Insufficient history after release.
        drive(0, 1'b1, 1'b0, "short_b0");
        drive(0, 1'b1, 1'b0, "short_b1");
        drive(0, 1'b0, 1'b0, "short_b2");

        // Reference stream for 1101: matches after bit index 4 and 7.
        pulse_reset(0, "ref_rst");
        ref_bits = 12'b0110_1101_1100;
        ref_exp  = 12'b0000_1001_0000;
        for (int k = 0; k < 12; k++) begin
            drive(0, ref_bits[11-k], ref_exp[11-k], $sformatf("ref_bit%0d", k));
        end
`ifdef SEQ_GEN_COUNT_EN
        chk8("ref_cnt", cnt[0], 8'd2);
`endif

        // Overlap with 1111: seven ones give four consecutive pulses.
        pulse_reset(1, "ovl_rst");
        for (int k = 0; k < 7; k++) begin
            drive(1, 1'b1, (k >= 3), $sformatf("ovl_bit%0d", k));
        end
`ifdef SEQ_GEN_COUNT_EN
        chk8("ovl_cnt", cnt[1], 8'd4);
`endif

        // Reset mid-match: 1,1,0 then reset, then 1 must not complete 1101.
        pulse_reset(0, "mid_rst0");
        drive(0, 1'b1, 1'b0, "mid_pre0");
        drive(0, 1'b1, 1'b0, "mid_pre1");
        drive(0, 1'b0, 1'b0, "mid_pre2");
        pulse_reset(0, "mid_rst1");
        drive(0, 1'b1, 1'b0, "mid_post0");
        // Fresh 1101 after the reset still matches.
        drive(0, 1'b1, 1'b0, "mid_post1");
        drive(0, 1'b0, 1'b0, "mid_post2");
        drive(0, 1'b1, 1'b1, "mid_post3");

        // Zero-fill guard with 0001.
        pulse_reset(2, "zf_rst");
        drive(2, 1'b1, 1'b0, "zf_single1");
        drive(2, 1'b0, 1'b0, "zf_b0");
        drive(2, 1'b0, 1'b0, "zf_b1");
        drive(2, 1'b0, 1'b0, "zf_b2");
        drive(2, 1'b1, 1'b1, "zf_b3");
        drive(2, 1'b1, 1'b0, "zf_after");
`ifdef SEQ_GEN_COUNT_EN
        chk8("zf_cnt", cnt[2], 8'd1);
`endif

        // Long run of ones on 1111: out keeps pulsing, counter saturates.
        pulse_reset(1, "sat_rst");
        for (int k = 0; k < 300; k++) begin
            drive(1, 1'b1, (k >= 3), $sformatf("sat_bit%0d", k));
`ifdef SEQ_GEN_COUNT_EN
            if (k == 257) chk8("sat_cnt_mid", cnt[1], 8'd255);
`endif
        end
`ifdef SEQ_GEN_COUNT_EN
        chk8("sat_cnt_end", cnt[1], 8'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
- Serial bit-stream pattern detector with overlapping match detection.
- Samples a 1-bit input every clock and pulses a registered (Moore-style) output for one cycle when the last W sampled bits equal PATTERN.
- Used as a control-path monitor for framing/sync words in a serial datapath.

Parameters:
- W, 4, pattern length in bits (2..16).
- PATTERN, 4'b1101, target sequence; MSB is the oldest bit and is received first.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
- in  input  1  serial data bit, sampled every rising clk edge.
- out  output  1  match pulse; registered.
- match_count  output  8  number of matches since reset; present only with SEQ_GEN_COUNT_EN.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - out=0.
  - Internal history shift register cleared.
  - Fill counter = 0.
  - match_count = 0 (when present).
- Every rising clk edge with reset=1:
  - History shifts left; in enters the LSB.
  - Fill counter increments, saturating at W.
- Output rule:
  - out is set to 1 at edge k when the fill counter (including the current bit) has reached W and history[W-1:0] equals PATTERN after the shift. Otherwise out is set to 0.
  - Latency: out rises in the clock cycle immediately after the edge that samples the final pattern bit.
  - out stays high for exactly one cycle per match.
- Overlap:
  - Matches may share bits; no state is discarded after a match.
  - Back-to-back matches are possible when PATTERN is self-overlapping (e.g. PATTERN=4'b1111 with a continuous 1 stream gives out=1 on every cycle after the 4th bit).
- Partial history:
  - Bits sampled before reset release never contribute to a match.
  - Fewer than W bits since reset never produce a match, even when the zero-filled register coincidentally equals PATTERN (e.g. PATTERN=4'b0001).
- Reset mid-stream:
  - History, fill counter and out clear immediately.
  - Detection restarts from scratch; partial matches are lost.
- Unknown input: an X on in must not propagate into out once W known bits have been shifted in. The bench drives known values only.
- No enable, no handshake: the input is consumed on every cycle.

Optional Feature:
- Macro: SEQ_GEN_COUNT_EN.
- Defined:
  - Adds the 8-bit output match_count.
  - match_count increments by 1 on the same edge that sets out=1.
  - Saturates at 255 (no wrap).
  - Cleared to 0 by reset.
- Undefined:
  - The port does not exist; no counter logic is present.
  - out behaviour is identical in both builds.

Test Plan:
- Reset: hold reset=0 for 2 cycles with arbitrary in -> out=0, match_count=0. Release, then drive 3 bits 1,1,0 -> out stays 0 (insufficient history).
- Reference stream: drive in = 0,1,1,0,1,1,0,1,1,1,0,0 (one bit per cycle, PATTERN=1101) -> out=1 exactly in the cycle after bit index 4 and after bit index 7, 0 elsewhere; match_count ends at 2.
- Overlap: PATTERN=4'b1111, drive 7 consecutive 1s -> out=1 for 4 consecutive cycles (after bits 4,5,6,7); match_count=4.
- Reset mid-match: drive 1,1,0, assert reset=0 asynchronously mid-cycle, release, then drive 1 -> out remains 0 (no match from pre-reset bits).
- Zero-fill guard: PATTERN=4'b0001, release reset, drive single 1 -> out=0. Then drive 0,0,0,1 -> out=1 once.
- Saturation (SEQ_GEN_COUNT_EN): PATTERN=4'b1111, drive 300 consecutive 1s -> match_count holds 255 and does not wrap; out continues pulsing every cycle.
